// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types, default width and terminal-value helper for counters
package counter_pkg;

    localparam int DEFAULT_CNT_WIDTH = 4;

    typedef logic [DEFAULT_CNT_WIDTH-1:0] cnt4_t;

    function automatic int terminal_value(input int modulus);
        return modulus - 1;
    endfunction

endpackage

// File: rtl/sync_up_counter.sv
// rtl/sync_up_counter.sv - free-running modulo-N up-counter with terminal-count decode
module sync_up_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_CNT_WIDTH,
    parameter int MODULUS = 2**WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    if (MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_modulus
        $error("sync_up_counter: MODULUS %0d outside legal range 2..%0d", MODULUS, 2**WIDTH);
    end

    localparam logic [WIDTH-1:0] TERM = WIDTH'(terminal_value(MODULUS));

    // Explicit compare also covers the full power-of-two case, where it matches natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (count == TERM) begin
            count <= '0;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == TERM);

endmodule

// File: tb/tb_sync_up_counter.sv
// tb/tb_sync_up_counter.sv - directed self-checking bench for sync_up_counter (mod-16 and mod-10)
module tb_sync_up_counter;

    logic       clk;
    logic       rst;
    logic [3:0] count16;
    logic       tc16;
    logic [3:0] count10;
    logic       tc10;

    int checks;
    int errors;
    int exp16;
    int exp10;
    bit found;

    sync_up_counter #(.WIDTH(4), .MODULUS(16)) u_dut16 (
        .clk   (clk),
        .rst   (rst),
        .count (count16),
        .tc    (tc16)
    );

    sync_up_counter #(.WIDTH(4), .MODULUS(10)) u_dut10 (
        .clk   (clk),
        .rst   (rst),
        .count (count10),
        .tc    (tc10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("count16", 32'(count16), 32'(exp16));
        check("tc16",    32'(tc16),    32'(exp16 == 15));
        check("count10", 32'(count10), 32'(exp10));
        check("tc10",    32'(tc10),    32'(exp10 == 9));
    endtask

    task automatic step_models();
        exp16 = (exp16 == 15) ? 0 : exp16 + 1;
        exp10 = (exp10 == 9)  ? 0 : exp10 + 1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp16  = 0;
        exp10  = 0;
        rst    = 1'b0;

        // Held in reset across ten rising edges.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_all();
        end

        rst = 1'b1;
        // 2000 ns of free running: first edge gives 1, wraps 15->0 and 9->0.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            step_models();
            check_all();
        end

        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            step_models();
            check_all();
            if (exp16 == 9) found = 1'b1;
        end
        check("reach_nine", 32'(found), 32'd1);

        // Short reset pulse between edges must clear immediately.
        #1 rst = 1'b0;
        #1;
        check("async_count16", 32'(count16), 32'd0);
        check("async_tc16",    32'(tc16),    32'd0);
        check("async_count10", 32'(count10), 32'd0);
        check("async_tc10",    32'(tc10),    32'd0);
        #2 rst = 1'b1;
        exp16 = 0;
        exp10 = 0;

        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            step_models();
            check_all();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_up_counter.md
Name: sync_up_counter

Overview:
- Free-running synchronous binary up-counter with a configurable modulus and a terminal-count flag.
- Every flop shares one clock and changes only on its rising edge.
- The one exception is the asynchronous active-low reset.
- Used as a basic timing and sequencing primitive; the default configuration is a 4-bit, mod-16 counter.

Parameters:
- WIDTH, 4, bit width of count.
- MODULUS, 2**WIDTH (16), number of states. Count sequence is 0 .. MODULUS-1, then wraps to 0. Legal range is 2 .. 2**WIDTH; elaboration error otherwise.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- count  output  WIDTH  current counter value, driven directly from a register.
- tc  output  1  terminal count; combinational decode, high while count == MODULUS-1.

Behaviour:
- Reset
  - rst falling to 0 immediately forces count = 0, independent of clk.
  - tc follows as 0, unless MODULUS == 1, which is illegal anyway.
  - While rst = 0, count holds 0 regardless of clock edges.
- Reset release
  - rst rising is sampled synchronously by the counting logic.
  - The first rising clk edge with rst = 1 moves count 0 -> 1.
  - No extra synchroniser is inside the block; the integrator guarantees release timing.
- Counting
  - On each rising clk edge with rst = 1: count <= (count == MODULUS-1) ? 0 : count + 1.
  - No enable, no load, no down mode; the counter always advances.
- Wrap-around
  - MODULUS-1 -> 0 on the next edge (default 15 -> 0). There is no sticky overflow.
  - tc is high for exactly one clock period per MODULUS cycles, namely the cycle in which count == MODULUS-1.
- Arithmetic
  - Unsigned, WIDTH bits.
  - When MODULUS == 2**WIDTH, the compare and natural overflow give the same result; the implementation may use either.
  - count never leaves the range 0 .. MODULUS-1.
- Reset mid-operation
  - Asserting rst at any count value clears to 0 asynchronously, even between clock edges.
  - A reset pulse shorter than a clock period still clears the counter.
- Latency
  - count is registered: one edge from state N to state N+1.
  - tc has zero latency relative to count.
- No X propagation after reset; every flop has a reset value.

Decomposition:
- Shared package counter_pkg:
  - localparam DEFAULT_CNT_WIDTH = 4.
  - Function for the terminal value, MODULUS-1, cast to WIDTH bits.
  - typedef logic [DEFAULT_CNT_WIDTH-1:0] cnt4_t for users of the default configuration.
- No sub-module; a single always_ff register plus next-state and tc decode is natural.
- Parameter legality checks go in an initial/elaboration assertion block.

Test Plan:
- Power-up reset: clk period 10 ns, rst = 0 for 100 ns.
  - Required: count == 0 and tc == 0 throughout, including across the 10 clock edges.
- Release and count: raise rst; over the next 15 rising edges.
  - Required: count reads 1, 2, ..., 15.
  - tc == 1 only while count == 15.
- Wrap: one more edge after 15.
  - Required: count == 0, tc == 0.
  - Over 2000 ns total, the sequence repeats with period 160 ns and there is never a skipped or repeated value.
- Asynchronous reset mid-count: at count == 9, drive rst = 0 for 3 ns, halfway between edges.
  - Required: count == 0 within the same cycle, before the next edge.
  - After rst = 1, count resumes 1, 2, ...
- Non-power-of-two modulus: WIDTH = 4, MODULUS = 10.
  - Required: sequence 0..9, 9 -> 0; tc high at 9; values 10..15 never appear.
- Illegal parameters: MODULUS = 1 or MODULUS = 17 with WIDTH = 4.
  - Required: elaboration fails with an assertion message.
